// File: rtl/spdif_pkg.sv
// Shared S/PDIF definitions: preamble patterns in transition form, preamble
// codes, subframe geometry and the decoder FSM states.
package spdif_pkg;

  localparam int SUBFRAME_CELLS = 64;
  localparam int PREAMBLE_CELLS = 8;
  localparam int POS_W          = $clog2(SUBFRAME_CELLS);

  typedef logic [POS_W-1:0] pos_t;

  // Preambles as transition bits, oldest cell in bit 7.  Every pattern
  // contains the run 1,0,0, which valid BMC data can never produce.
  localparam logic [7:0] PRE_B = 8'b10011100;
  localparam logic [7:0] PRE_M = 8'b10010011;
  localparam logic [7:0] PRE_W = 8'b10010110;

  typedef enum logic [1:0] {
    CODE_NONE = 2'd0,
    CODE_B    = 2'd1,
    CODE_M    = 2'd2,
    CODE_W    = 2'd3
  } preamble_code_e;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/spdif_bmc_decoder_if.sv
// Word stream out of the BMC decoder: valid/ready handshake carrying
// transition bits and the preamble code of the subframe's first word.
interface spdif_bmc_decoder_if #(
  parameter int width = 4
);

  logic             o_valid;
  logic             o_ready;
  logic [width-1:0] o_data;
  logic [1:0]       o_preamble;

  modport master (
    output o_valid,
    output o_data,
    output o_preamble,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    input  o_preamble,
    output o_ready
  );

endinterface

// File: rtl/spdif_preamble_detector.sv
// Combinational B/M/W preamble match on an 8-cell transition window.
// Shared between the BMC decoder and the frame decoder.
module spdif_preamble_detector
  import spdif_pkg::*;
(
  input  logic [7:0]     window,
  output logic           hit,
  output preamble_code_e code
);

  // Map the window onto a preamble code; anything else is no match.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before the
    // case, so no path leaves it unassigned and no latch is inferred.
    code = CODE_NONE;
    case (window)
      PRE_B:   code = CODE_B;
      PRE_M:   code = CODE_M;
      PRE_W:   code = CODE_W;
      default: code = CODE_NONE;
    endcase
  end

  assign hit = (code != CODE_NONE);

endmodule

// File: rtl/spdif_bmc_decoder.sv
// S/PDIF BMC receive front end: turns line levels into transition bits,
// locks onto subframe preambles and emits width-bit words MSB-first.
module spdif_bmc_decoder
  import spdif_pkg::*;
#(
  parameter int width = 4
) (
  input  logic                       clk128,
  input  logic                       reset,
  input  logic                       i_line,
  spdif_bmc_decoder_if.master        bus,
  output logic                       o_locked,
  output logic                       o_bmc_error,
  output logic                       o_sync_error,
  output logic                       is_overrun
);

  localparam pos_t PRE_LAST   = pos_t'(PREAMBLE_CELLS - 1);
  localparam pos_t DATA_FIRST = pos_t'(PREAMBLE_CELLS);
  localparam pos_t DATA_LAST  = pos_t'(SUBFRAME_CELLS - 2);
  localparam pos_t WORD_MASK  = pos_t'(width - 1);

  logic           line_prev;
  logic [6:0]     sr;          // older seven cells of the window
  logic [7:0]     sr_next;     // full window including the live cell
  logic           t;
  pos_t           pos, pos_next;
  state_e         state, state_next;
  logic           hit;
  preamble_code_e code;
  logic           emit;
  logic           sync_err_next;
  logic           bmc_err_next;

  assign t       = i_line ^ line_prev;
  assign sr_next = {sr, t};

  spdif_preamble_detector u_detector (
    .window (sr_next),
    .hit    (hit),
    .code   (code)
  );

  // Alignment FSM: hunt for a preamble, then track the cell index and
  // demand a preamble at every subframe start.
  always_comb begin
    state_next    = state;
    pos_next      = pos;
    sync_err_next = 1'b0;
    bmc_err_next  = 1'b0;
    case (state)
      HUNT: begin
        if (hit) begin
          state_next = LOCKED;
          pos_next   = PRE_LAST;
        end
      end
      LOCKED: begin
        pos_next = pos + pos_t'(1);
        if (pos_next == PRE_LAST && !hit) begin
          state_next    = HUNT;
          sync_err_next = 1'b1;
        end
        // Every data bit cell must open with a transition.
        if (!pos_next[0] && pos_next >= DATA_FIRST && pos_next <= DATA_LAST && !t)
          bmc_err_next = 1'b1;
      end
      default: state_next = HUNT;
    endcase
    // Word boundaries line up with the preamble end because width divides 8.
    emit = (state_next == LOCKED) && ((pos_next & WORD_MASK) == (PRE_LAST & WORD_MASK));
  end

  // Line history, transition window and alignment state.
  always_ff @(posedge clk128) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      line_prev <= 1'b0;
      sr        <= '0;
      pos       <= '0;
      state     <= HUNT;
    end else begin
      line_prev <= i_line;
      sr        <= sr_next[6:0];
      pos       <= pos_next;
      state     <= state_next;
    end
  end

  // Output word register, handshake and one-cycle status pulses.  The line
  // cannot be stalled, so an unaccepted word is simply overwritten.
  always_ff @(posedge clk128) begin
    if (reset) begin
      bus.o_valid    <= 1'b0;
      bus.o_data     <= '0;
      bus.o_preamble <= CODE_NONE;
      o_bmc_error    <= 1'b0;
      o_sync_error   <= 1'b0;
      is_overrun     <= 1'b0;
    end else begin
      o_bmc_error  <= bmc_err_next;
      o_sync_error <= sync_err_next;
      is_overrun   <= emit && bus.o_valid && !bus.o_ready;
      if (emit) begin
        bus.o_valid    <= 1'b1;
        bus.o_data     <= sr_next[7 -: width];
        bus.o_preamble <= (pos_next == PRE_LAST) ? code : CODE_NONE;
      end else if (bus.o_ready) begin
        bus.o_valid <= 1'b0;
      end
    end
  end

  assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_spdif_bmc_decoder.sv
// Directed bench for spdif_bmc_decoder (width 4): builds BMC subframes in
// transition form, drives line levels and scoreboards the emitted words.
module tb_spdif_bmc_decoder;
  import spdif_pkg::*;

  localparam int WIDTH = 4;

  logic clk128 = 1'b0;
  logic reset;
  logic i_line;
  logic o_locked, o_bmc_error, o_sync_error, is_overrun;

  always #5 clk128 = ~clk128;

  spdif_bmc_decoder_if #(.width(WIDTH)) bus ();

  spdif_bmc_decoder #(.width(WIDTH)) dut (
    .clk128       (clk128),
    .reset        (reset),
    .i_line       (i_line),
    .bus          (bus),
    .o_locked     (o_locked),
    .o_bmc_error  (o_bmc_error),
    .o_sync_error (o_sync_error),
    .is_overrun   (is_overrun)
  );

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] pre;
  } word_t;

  word_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    bmc_cnt = 0;
  int    sync_cnt = 0;
  int    ovr_cnt = 0;
  logic  line_lvl = 1'b0;

  // Bench-side preamble patterns (transition form, oldest cell first).
  logic [7:0] pat_b = 8'b10011100;
  logic [7:0] pat_m = 8'b10010011;
  logic [7:0] pat_w = 8'b10010110;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 64 transition cells, cell 0 in bit 63; each data bit is a boundary
  // transition followed by the bit value in the second half-cell.
  function automatic logic [63:0] make_sf(input logic [7:0] pre, input logic [27:0] bits);
    logic [63:0] c;
    c[63:56] = pre;
    for (int k = 0; k < 28; k++) begin
      c[55-2*k] = 1'b1;
      c[54-2*k] = bits[27-k];
    end
    return c;
  endfunction

  // Expected words of one subframe; word k covers cells 4k..4k+3 and is
  // emitted once cell 4k+7 has been sampled (word 15 lands in the next one).
  task automatic push_words(input logic [63:0] c, input int n_cells, input int skip_k,
                            input logic [1:0] pre_code);
    word_t w;
    for (int k = 0; k < 16; k++) begin
      if ((n_cells == 64 || 4*k + 7 <= n_cells - 1) && k != skip_k) begin
        w.data = c[63-4*k -: 4];
        w.pre  = (k == 0) ? pre_code : 2'd0;
        exp_q.push_back(w);
      end
    end
  endtask

  // Drive cells as line levels; iteration i runs just after cell i-1 was sampled.
  task automatic send(input logic [63:0] c, input int n_cells, input bit lock_chk,
                      input bit ovr_test);
    for (int i = 0; i < n_cells; i++) begin
      @(posedge clk128); #1;
      if (lock_chk && i == 7) check("lock_before_cell7", o_locked, 1'b0);
      if (lock_chk && i == 8) check("lock_after_cell7", o_locked, 1'b1);
      if (ovr_test) begin
        if (i == 17) bus.o_ready = 1'b0;
        if (i == 20) begin
          check("ovr_first_valid", bus.o_valid, 1'b1);
          check("ovr_first_no_pulse", is_overrun, 1'b0);
        end
        if (i == 24) begin
          check("ovr_pulse", is_overrun, 1'b1);
          check("ovr_data_second", bus.o_data, c[47:44]);
        end
        if (i == 26) bus.o_ready = 1'b1;
      end
      line_lvl = line_lvl ^ c[63-i];
      i_line   = line_lvl;
    end
  endtask

  // Output monitor: counts status pulses and scoreboards accepted words.
  always @(negedge clk128) begin : monitor
    word_t w;
    if (o_bmc_error === 1'b1)  bmc_cnt++;
    if (o_sync_error === 1'b1) sync_cnt++;
    if (is_overrun === 1'b1)   ovr_cnt++;
    if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("word_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        w = exp_q.pop_front();
        check("word_data", bus.o_data, w.data);
        check("word_pre", bus.o_preamble, w.pre);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout observed running expected finished");
    $fatal(1);
  end

  initial begin : stimulus
    logic [63:0] sf;
    logic [63:0] bogus;

    reset       = 1'b1;
    i_line      = 1'b0;
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk128);
    #1;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_locked", o_locked, 1'b0);
    check("rst_data", bus.o_data, 4'h0);
    check("rst_pre", bus.o_preamble, 2'd0);
    reset = 1'b0;

    // Idle line: nothing locks, nothing is emitted.
    repeat (100) @(posedge clk128);
    #1;
    check("idle_locked", o_locked, 1'b0);
    check("idle_valid", bus.o_valid, 1'b0);
    check("idle_err_pulses", 32'(bmc_cnt + sync_cnt + ovr_cnt), 32'd0);

    // B subframe with all-zero data, lock timing checked.
    sf = make_sf(pat_b, 28'h0);
    push_words(sf, 64, -1, CODE_B);
    send(sf, 64, 1'b1, 1'b0);

    sf = make_sf(pat_m, 28'($urandom()));
    push_words(sf, 64, -1, CODE_M);
    send(sf, 64, 1'b0, 1'b0);

    sf = make_sf(pat_w, 28'($urandom()));
    push_words(sf, 64, -1, CODE_W);
    send(sf, 64, 1'b0, 1'b0);
    check("mw_no_bmc_err", 32'(bmc_cnt), 32'd0);
    check("mw_no_sync_err", 32'(sync_cnt), 32'd0);

    // Missing boundary transition at cell 20.
    sf = make_sf(pat_b, 28'($urandom()));
    sf[63-20] = 1'b0;
    push_words(sf, 64, -1, CODE_B);
    send(sf, 64, 1'b0, 1'b0);
    check("bmc_err_once", 32'(bmc_cnt), 32'd1);
    check("bmc_keeps_lock", o_locked, 1'b1);

    sf = make_sf(pat_m, 28'($urandom()));
    push_words(sf, 64, -1, CODE_M);
    send(sf, 64, 1'b0, 1'b0);

    // Preamble slot filled with ordinary BMC data: lock must drop.
    for (int p = 0; p < 32; p++) begin
      bogus[63-2*p] = 1'b1;
      bogus[62-2*p] = 1'($urandom());
    end
    send(bogus, 64, 1'b0, 1'b0);
    check("sync_err_once", 32'(sync_cnt), 32'd1);
    check("sync_lock_lost", o_locked, 1'b0);
    check("sync_no_pending", 32'(exp_q.size()), 32'd0);

    sf = make_sf(pat_b, 28'($urandom()));
    push_words(sf, 64, -1, CODE_B);
    send(sf, 64, 1'b0, 1'b0);
    check("relock", o_locked, 1'b1);

    // Consumer stalls across two emissions: the first is overwritten.
    sf = make_sf(pat_m, 28'($urandom()));
    push_words(sf, 64, 3, CODE_M);
    send(sf, 64, 1'b0, 1'b1);
    check("ovr_count", 32'(ovr_cnt), 32'd1);

    // Reset mid-subframe with an unconsumed word pending.
    sf = make_sf(pat_w, 28'($urandom()));
    push_words(sf, 23, -1, CODE_W);
    send(sf, 24, 1'b0, 1'b0);
    bus.o_ready = 1'b0;
    @(posedge clk128); #1;
    check("pre_rst_pending", bus.o_valid, 1'b1);
    reset  = 1'b1;
    i_line = 1'b0;
    @(posedge clk128); #1;
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_locked", o_locked, 1'b0);
    check("mid_rst_data", bus.o_data, 4'h0);
    check("mid_rst_pre", bus.o_preamble, 2'd0);
    check("mid_rst_pulses", {o_bmc_error, o_sync_error, is_overrun}, 3'b000);
    reset       = 1'b0;
    bus.o_ready = 1'b1;
    repeat (10) @(posedge clk128);
    #1;
    check("post_rst_valid", bus.o_valid, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
